frame_capture: RTL and testbench

//  Writer side of the frame-buffer BRAM. The display path reads this BRAM and unpacks RGB332 back to 24-bit colour.
//  On a capture request, the block arms. It waits for the start of the next frame.
//  It then packs every active-area output pixel (24-bit RGB) to RGB332 and writes it to BRAM in raster order.
//  It reports progress on bram_state (BRAM_IDLE / CAPTURE_FRAME / WRITING_FRAME) for the top-level FSM.

---
 rtl/frame_capture.sv | 69 ++++++
 tb/tb_frame_capture.sv | 124 ++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
// frame_capture: arms on start, waits for the next frame start, then writes every active pixel as RGB332 to BRAM in raster order.
module frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 400,
  parameter int ADDR_W   = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [23:0]       pix_in,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic              bram_we,
  output logic              busy,
  output logic              done,
  output logic [1:0]        bram_state
);
  typedef enum logic [1:0] {IDLE, ARMED, WRITING, DONE} state_t;
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic we_q, we_d, done_q, done_d;
  logic active, frame_start, last_pix, wr;
  always_comb begin
    active      = (hcount <= H_LAST) && (vcount <= V_LAST);
    frame_start = (hcount == '0) && (vcount == '0);
    last_pix    = (hcount == H_LAST) && (vcount == V_LAST);
    wr          = !abort && ((state_q == ARMED && frame_start) || (state_q == WRITING && active));
    we_d        = wr;
    addr_d      = wr ? (state_q == ARMED ? '0 : cnt_q) : addr_q;
    din_d       = wr ? {pix_in[23:21], pix_in[15:13], pix_in[7:6]} : din_q;
    cnt_d       = wr ? addr_d + ADDR_W'(1) : cnt_q;
    done_d      = state_q == DONE;
    // Completion is keyed on the last raster position, so a restarted frame_start mid-write is simply ignored.
    state_d     = abort                            ? IDLE :
                  state_q == IDLE                  ? (start ? ARMED : IDLE) :
                  state_q == DONE                  ? IDLE :
                  (wr && last_pix)                 ? DONE :
                  (state_q == ARMED && frame_start) ? WRITING : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end
  assign bram_addr  = addr_q;
  assign bram_din   = din_q;
  assign bram_we    = we_q;
  assign done       = done_q;
  assign busy       = (state_q == ARMED) || (state_q == WRITING);
  assign bram_state = state_q == ARMED ? 2'b01 : state_q == WRITING ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: random pixels over a small raster, checked against a capture model driven by raster position.
module tb_frame_capture;
  localparam int H = 8, V = 4, HT = 12, VT = 6, AW = 5;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [23:0] pix_in = '0;
  logic [10:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic [AW-1:0] bram_addr;
  logic [7:0] bram_din;
  logic bram_we, busy, done;
  logic [1:0] bram_state;
  int checks = 0, failures = 0;
  int phase = 0, writes = 0, dones = 0, h = 0, v = 0;
  frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pix_in(pix_in),
    .hcount(hcount), .vcount(vcount), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_we(bram_we), .busy(busy), .done(done), .bram_state(bram_state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // phase: 0 idle, 1 waiting for frame start, 2 capturing, 3 capture finished
  task automatic cycle(input logic s, input logic a, input logic r, input logic [23:0] p);
    logic act, fs, lst, we, exp_done;
    int np;
    hcount = 11'(h);
    vcount = 10'(v);
    pix_in = p;
    start  = s;
    abort  = a;
    reset  = r;
    act = (h < H) && (v < V);
    fs  = (h == 0) && (v == 0);
    lst = (h == H - 1) && (v == V - 1);
    we  = !r && !a && ((phase == 1 && fs) || (phase == 2 && act));
    if (r || a) np = 0;
    else if (phase == 0) np = s ? 1 : 0;
    else if (phase == 1) np = fs ? 2 : 1;
    else if (phase == 2) np = (we && lst) ? 3 : 2;
    else np = 0;
    exp_done = !r && phase == 3;
    @(posedge clk);
    #1;
    chk("we", 32'(bram_we), 32'(we));
    if (we) begin
      chk("addr", 32'(bram_addr), 32'(v * H + h));
      chk("din", 32'(bram_din), 32'({p[23:21], p[15:13], p[7:6]}));
    end
    if (r) begin
      chk("rst_addr", 32'(bram_addr), 32'd0);
      chk("rst_din", 32'(bram_din), 32'd0);
    end
    chk("busy", 32'(busy), 32'(np == 1 || np == 2));
    chk("done", 32'(done), 32'(exp_done));
    chk("state", 32'(bram_state), np == 1 ? 32'd1 : np == 2 ? 32'd2 : 32'd0);
    if (bram_we === 1'b1) writes++;
    if (done === 1'b1) dones++;
    phase = np;
    h = (h + 1) % HT;
    if (h == 0) v = (v + 1) % VT;
    start = 1'b0;
    abort = 1'b0;
  endtask
  task automatic goto(input int th, input int tv);
    for (int i = 0; i < HT * VT && !(h == th && v == tv); i++) cycle(1'b0, 1'b0, 1'b0, 24'($urandom));
  endtask
  task automatic finish_capture(input logic noisy);
    for (int i = 0; i < 4 * HT * VT && phase != 0; i++)
      cycle(noisy && (phase == 3 || (phase == 2 && $urandom_range(0, 3) == 0)), 1'b0, 1'b0, 24'($urandom));
    chk("capture_ended", 32'(phase), 32'd0);
  endtask
  task automatic wait_writes(input int n);
    for (int i = 0; i < 4 * HT * VT && writes < n; i++) cycle(1'b0, 1'b0, 1'b0, 24'($urandom));
    chk("write_target", 32'(writes), 32'(n));
  endtask
  initial begin
    cycle(1'b0, 1'b0, 1'b1, 24'($urandom));
    cycle(1'b0, 1'b0, 1'b1, 24'($urandom));
    cycle(1'b1, 1'b1, 1'b0, 24'($urandom));
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 24'($urandom));
    goto(3, 2);
    cycle(1'b1, 1'b0, 1'b0, 24'($urandom));
    goto(0, 0);
    writes = 0;
    dones = 0;
    cycle(1'b0, 1'b0, 1'b0, 24'hFF8040);
    chk("pack", 32'(bram_din), 32'h0000_00F1);
    finish_capture(1'b0);
    chk("full_writes", 32'(writes), 32'd32);
    chk("full_dones", 32'(dones), 32'd1);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 24'($urandom));
    writes = 0;
    dones = 0;
    cycle(1'b1, 1'b0, 1'b0, 24'($urandom));
    wait_writes(11);
    cycle(1'b0, 1'b1, 1'b0, 24'($urandom));
    repeat (80) cycle(1'b0, 1'b0, 1'b0, 24'($urandom));
    chk("abort_writes", 32'(writes), 32'd11);
    chk("abort_dones", 32'(dones), 32'd0);
    writes = 0;
    cycle(1'b1, 1'b0, 1'b0, 24'($urandom));
    finish_capture(1'b0);
    chk("after_abort_writes", 32'(writes), 32'd32);
    writes = 0;
    dones = 0;
    cycle(1'b1, 1'b0, 1'b0, 24'($urandom));
    finish_capture(1'b1);
    chk("noisy_writes", 32'(writes), 32'd32);
    chk("noisy_dones", 32'(dones), 32'd1);
    writes = 0;
    cycle(1'b1, 1'b0, 1'b0, 24'($urandom));
    wait_writes(6);
    cycle(1'b0, 1'b0, 1'b1, 24'($urandom));
    repeat (80) cycle(1'b0, 1'b0, 1'b0, 24'($urandom));
    chk("reset_writes", 32'(writes), 32'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
